// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory round-robin arbiter: request bundle,
// port identifier and arbiter FSM encoding.
package mem_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef logic port_id_t;

  typedef struct packed {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
  } mem_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/id_fifo.sv
// Synchronous FIFO of issuing-port IDs, one entry per read accepted by memory
// and not yet returned. Reset is asynchronous, active-high.
module id_fifo
  import mem_arb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  port_id_t push_id,
  input  logic     pop,
  output port_id_t head,
  output logic     full,
  output logic     empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  port_id_t      entries [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = entries[rd_ptr];

  // NOTE: storage carries no reset; an entry is only read after it was written, and the pointers/count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_id;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one 128-bit memory request channel between the
// fetch (0) and data (1) ports, routing in-order read returns back to the issuer.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int OUTST_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           port_req_i,
  input  logic [1:0]           port_we_i,
  input  logic [1:0][31:0]     port_addr_i,
  input  logic [1:0][127:0]    port_wdata_i,
  input  logic [1:0][15:0]     port_wstrb_i,
  output logic [1:0]           port_gnt_o,
  output logic [1:0][127:0]    port_rdata_o,
  output logic [1:0]           port_rvalid_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [127:0]         mem_wdata_o,
  output logic [15:0]          mem_wstrb_o,
  input  logic                 mem_gnt_i,
  input  logic [127:0]         mem_rdata_i,
  input  logic                 mem_rvalid_i,
  output logic                 err_o
);

  localparam int CW = $clog2(OUTST_DEPTH);

  arb_state_e state;
  port_id_t   owner;
  port_id_t   rr_ptr;
  port_id_t   sel;
  logic       sel_valid;
  logic [1:0] cand;
  mem_req_t   port_bundle [NUM_PORTS];
  mem_req_t   out_req;

  logic       fifo_push;
  logic       fifo_pop;
  port_id_t   fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic [CW:0] fifo_count;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_bundle[p] = '{we:    port_we_i[p],
                         addr:  port_addr_i[p],
                         wdata: port_wdata_i[p],
                         wstrb: port_wstrb_i[p]};
    end
  end

  // Reads are held back while every outstanding slot is in use; writes always compete.
  assign cand = port_req_i & (port_we_i | {2{~fifo_full}});

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sel       = owner;
    sel_valid = 1'b0;
    case (state)
      IDLE: begin
        sel_valid = |cand;
        sel       = (&cand) ? rr_ptr : port_id_t'(cand[1]);
      end
      HOLD: begin
        sel_valid = 1'b1;
        sel       = owner;
      end
      default: begin
        sel_valid = 1'b0;
        sel       = owner;
      end
    endcase
    // Outputs read as idle while reset is held, including mid-transaction.
    if (rst_i) sel_valid = 1'b0;
  end

  assign out_req     = sel_valid ? port_bundle[sel] : '0;
  assign mem_req_o   = sel_valid;
  assign mem_we_o    = out_req.we;
  assign mem_addr_o  = out_req.addr;
  assign mem_wdata_o = out_req.wdata;
  assign mem_wstrb_o = out_req.wstrb;

  assign fifo_push = sel_valid & mem_gnt_i & ~out_req.we;
  assign fifo_pop  = mem_rvalid_i & ~fifo_empty & ~rst_i;

  always_comb begin
    port_gnt_o    = '0;
    port_rvalid_o = '0;
    port_rdata_o  = '0;
    if (sel_valid && mem_gnt_i) port_gnt_o[sel] = 1'b1;
    if (fifo_pop) begin
      port_rvalid_o[fifo_head] = 1'b1;
      port_rdata_o[fifo_head]  = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      if (mem_rvalid_i && fifo_empty) err_o <= 1'b1;
      if (sel_valid && mem_gnt_i) begin
        rr_ptr <= ~sel;
        state  <= IDLE;
      end else if (sel_valid && state == IDLE) begin
        owner <= sel;
        state <= HOLD;
      end
    end
  end

  id_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (fifo_push),
    .push_id (sel),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: alternation, hold, full blocking,
// error flag, mid-transaction reset and same-cycle push/pop routing.
module tb_mem_rr_arbiter;

  logic              clk;
  logic              rst;
  logic [1:0]        port_req;
  logic [1:0]        port_we;
  logic [1:0][31:0]  port_addr;
  logic [1:0][127:0] port_wdata;
  logic [1:0][15:0]  port_wstrb;
  logic [1:0]        port_gnt;
  logic [1:0][127:0] port_rdata;
  logic [1:0]        port_rvalid;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [127:0]      mem_wdata;
  logic [15:0]       mem_wstrb;
  logic              mem_gnt;
  logic [127:0]      mem_rdata;
  logic              mem_rvalid;
  logic              err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_rr_arbiter #(.OUTST_DEPTH(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .port_req_i    (port_req),
    .port_we_i     (port_we),
    .port_addr_i   (port_addr),
    .port_wdata_i  (port_wdata),
    .port_wstrb_i  (port_wstrb),
    .port_gnt_o    (port_gnt),
    .port_rdata_o  (port_rdata),
    .port_rvalid_o (port_rvalid),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_wstrb_o   (mem_wstrb),
    .mem_gnt_i     (mem_gnt),
    .mem_rdata_i   (mem_rdata),
    .mem_rvalid_i  (mem_rvalid),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic [31:0] addr);
    port_req[p]   = req;
    port_we[p]    = we;
    port_addr[p]  = addr;
    port_wdata[p] = we ? {4{addr}} : '0;
    port_wstrb[p] = we ? 16'hF0F0 : '0;
  endtask

  task automatic set_ret(input logic v, input logic [127:0] d);
    mem_rvalid = v;
    mem_rdata  = d;
  endtask

  initial begin
    rst = 1'b1;
    port_req = '0; port_we = '0; port_addr = '0; port_wdata = '0; port_wstrb = '0;
    mem_gnt = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    #3;
    check("rst_mem_req", mem_req, 0);
    check("rst_gnt", port_gnt, 0);
    check("rst_rvalid", port_rvalid, 0);
    check("rst_rdata", port_rdata, 0);
    check("rst_err", err, 0);
    check("rst_addr", mem_addr, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Continuous contention with grant tied high: ports alternate, returns route in order.
    next_cycle();
    set_port(0, 1, 0, 32'h1000); set_port(1, 1, 0, 32'h2000); mem_gnt = 1'b1;
    settle();
    check("alt_gnt0", port_gnt, 2'b01);
    check("alt_addr0", mem_addr, 32'h1000);
    next_cycle(); settle();
    check("alt_gnt1", port_gnt, 2'b10);
    check("alt_addr1", mem_addr, 32'h2000);
    next_cycle(); set_ret(1, 128'hD0); settle();
    check("alt_gnt2", port_gnt, 2'b01);
    check("alt_rv0", port_rvalid, 2'b01);
    check("alt_rd0", port_rdata[0], 128'hD0);
    check("alt_rd0_other", port_rdata[1], 0);
    next_cycle(); set_ret(1, 128'hD1); settle();
    check("alt_gnt3", port_gnt, 2'b10);
    check("alt_rv1", port_rvalid, 2'b10);
    check("alt_rd1", port_rdata[1], 128'hD1);
    check("alt_rd1_other", port_rdata[0], 0);
    next_cycle(); port_req = '0; set_ret(1, 128'hD2); settle();
    check("alt_rv2", port_rvalid, 2'b01);
    check("alt_rd2", port_rdata[0], 128'hD2);
    next_cycle(); set_ret(1, 128'hD3); settle();
    check("alt_rv3", port_rvalid, 2'b10);
    check("alt_rd3", port_rdata[1], 128'hD3);
    next_cycle(); set_ret(0, 0); settle();
    check("alt_count", dut.fifo_count, 0);
    check("alt_idle", mem_req, 0);

    // Port 1 write held under mem_gnt low; port 0 joins but must wait.
    next_cycle();
    set_port(1, 1, 1, 32'h40); mem_gnt = 1'b0; settle();
    check("hold_c1_req", mem_req, 1);
    check("hold_c1_addr", mem_addr, 32'h40);
    check("hold_c1_we", mem_we, 1);
    check("hold_c1_wstrb", mem_wstrb, 16'hF0F0);
    check("hold_c1_gnt", port_gnt, 0);
    next_cycle(); set_port(0, 1, 0, 32'h80); settle();
    check("hold_c2_addr", mem_addr, 32'h40);
    check("hold_c2_gnt", port_gnt, 0);
    next_cycle(); settle();
    check("hold_c3_addr", mem_addr, 32'h40);
    check("hold_c3_wdata", mem_wdata, {4{32'h40}});
    next_cycle(); mem_gnt = 1'b1; settle();
    check("hold_c4_gnt", port_gnt, 2'b10);
    check("hold_c4_addr", mem_addr, 32'h40);
    next_cycle(); set_port(1, 0, 0, 0); settle();
    check("hold_c5_gnt", port_gnt, 2'b01);
    check("hold_c5_addr", mem_addr, 32'h80);
    check("hold_c5_we", mem_we, 0);
    next_cycle(); set_port(0, 0, 0, 0); mem_gnt = 1'b0; set_ret(1, 128'hD4); settle();
    check("hold_ret", port_rvalid, 2'b01);
    check("hold_ret_data", port_rdata[0], 128'hD4);

    // Fill all outstanding slots from port 0.
    for (int i = 0; i < 4; i++) begin
      next_cycle(); set_ret(0, 0); mem_gnt = 1'b1;
      set_port(0, 1, 0, 32'h100 + 32'(i * 16)); settle();
      check("fill_gnt", port_gnt, 2'b01);
    end
    next_cycle();
    set_port(0, 1, 0, 32'h500); set_port(1, 1, 1, 32'h600); settle();
    check("full_count", dut.fifo_count, 4);
    check("full_gnt", port_gnt, 2'b10);
    check("full_addr", mem_addr, 32'h600);
    check("full_we", mem_we, 1);
    next_cycle(); set_port(1, 0, 0, 0); mem_gnt = 1'b0; set_ret(1, 128'hD5); settle();
    check("full_blocked", mem_req, 0);
    check("full_pop_rv", port_rvalid, 2'b01);
    check("full_pop_rd", port_rdata[0], 128'hD5);
    next_cycle(); set_ret(0, 0); mem_gnt = 1'b1; settle();
    check("unblk_req", mem_req, 1);
    check("unblk_addr", mem_addr, 32'h500);
    check("unblk_gnt", port_gnt, 2'b01);
    next_cycle(); set_port(0, 0, 0, 0); set_ret(1, 128'hD6); settle();
    check("drain_rv", port_rvalid, 2'b01);

    // Push and pop in the same cycle at count 3.
    next_cycle(); set_port(1, 1, 0, 32'h700); set_ret(1, 128'hD7); settle();
    check("pp_count_before", dut.fifo_count, 3);
    check("pp_gnt", port_gnt, 2'b10);
    check("pp_rv", port_rvalid, 2'b01);
    check("pp_rd", port_rdata[0], 128'hD7);
    next_cycle(); set_port(1, 0, 0, 0); mem_gnt = 1'b0; set_ret(1, 128'hD8); settle();
    check("pp_count_after", dut.fifo_count, 3);
    check("pp_ret1", port_rvalid, 2'b01);
    check("pp_ret1_d", port_rdata[0], 128'hD8);
    next_cycle(); set_ret(1, 128'hD9); settle();
    check("pp_ret2", port_rvalid, 2'b01);
    next_cycle(); set_ret(1, 128'hDA); settle();
    check("pp_ret3", port_rvalid, 2'b10);
    check("pp_ret3_d", port_rdata[1], 128'hDA);
    check("pp_ret3_other", port_rdata[0], 0);
    next_cycle(); set_ret(0, 0); settle();
    check("pp_empty", dut.fifo_count, 0);

    // Return with nothing outstanding raises a sticky error.
    next_cycle(); set_ret(1, 128'hBAD); settle();
    check("err_rv", port_rvalid, 0);
    check("err_rd", port_rdata, 0);
    check("err_same_cycle", err, 0);
    next_cycle(); set_ret(0, 0); settle();
    check("err_set", err, 1);
    next_cycle(); settle();
    check("err_sticky", err, 1);

    // Two reads outstanding, port 1 held, then reset mid-transaction.
    next_cycle(); set_port(1, 1, 0, 32'h900); mem_gnt = 1'b1; settle();
    check("pre_rst_gnt1", port_gnt, 2'b10);
    next_cycle(); set_port(1, 0, 0, 0); set_port(0, 1, 0, 32'h800); settle();
    check("pre_rst_gnt0", port_gnt, 2'b01);
    next_cycle(); set_port(0, 0, 0, 0); set_port(1, 1, 0, 32'hA00); mem_gnt = 1'b0; settle();
    check("pre_rst_addr", mem_addr, 32'hA00);
    next_cycle(); settle();
    check("pre_rst_count", dut.fifo_count, 2);
    rst = 1'b1; #1;
    check("rst_hold_req", mem_req, 0);
    check("rst_hold_count", dut.fifo_count, 0);
    check("rst_hold_err", err, 0);
    check("rst_hold_gnt", port_gnt, 0);
    next_cycle(); rst = 1'b0;
    set_port(0, 1, 0, 32'hC00); set_port(1, 1, 0, 32'hD00); mem_gnt = 1'b1; settle();
    check("post_rst_tie", port_gnt, 2'b01);
    check("post_rst_addr", mem_addr, 32'hC00);
    next_cycle(); settle();
    check("post_rst_alt", port_gnt, 2'b10);
    next_cycle(); port_req = '0; mem_gnt = 1'b0; settle();
    check("post_rst_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
